// File: rtl/memory_stage_if.sv
// Request/response bundle for the byte-serial data-memory stage.
// The stage drives busy/done/valM/dmem_error; the requester drives the rest.
interface memory_stage_if;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic        dmem_error;

  modport master (
    output start, icode, valE, valA, valP,
    input  busy, done, valM, dmem_error
  );

  modport slave (
    input  start, icode, valE, valA, valP,
    output busy, done, valM, dmem_error
  );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 data-memory stage: one 64-bit access moved one byte per cycle,
// little-endian, against an internal byte array.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input logic          clk,
  input logic          reset,
  memory_stage_if.slave bus
);
  localparam int          AW   = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  mem [MEM_BYTES];
  logic [AW-1:0] base;
  logic [2:0]  cnt;
  logic        rd_q;
  logic [63:0] wbuf;
  logic [55:0] rbuf;

  logic        dec_wr;
  logic        dec_rd;
  logic [63:0] dec_addr;
  logic [63:0] dec_data;
  logic        oor;
  logic        accept;
  logic [AW-1:0] idx;
  logic [7:0]  rbyte;

  always_comb begin
    dec_wr   = 1'b0;
    dec_rd   = 1'b0;
    dec_addr = bus.valE;
    dec_data = bus.valA;
    unique case (1'b1)
      bus.icode == 4'h4,
      bus.icode == 4'hA: dec_wr = 1'b1;
      bus.icode == 4'h8: begin
        dec_wr   = 1'b1;
        dec_data = bus.valP;
      end
      bus.icode == 4'h5: dec_rd = 1'b1;
      bus.icode == 4'hB,
      bus.icode == 4'h9: begin
        dec_rd   = 1'b1;
        dec_addr = bus.valA;
      end
      default: ;
    endcase
  end

  // Full-width unsigned compare so huge addresses never wrap into range.
  assign oor    = dec_addr > LAST;
  // DONE accepts a new request on its exit edge for a zero-bubble restart.
  assign accept = bus.start && (state != XFER);
  assign idx    = base + AW'(cnt);
  assign rbyte  = mem[idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.dmem_error <= 1'b0;
      bus.valM       <= 64'd0;
      cnt            <= 3'd0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: ;
        XFER: begin
          cnt  <= cnt + 3'd1;
          wbuf <= wbuf >> 8;
          rbuf <= {rbyte, rbuf[55:8]};
          if (cnt == 3'd7) begin
            state    <= DONE;
            bus.done <= 1'b1;
            if (rd_q)
              bus.valM <= {rbyte, rbuf};
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        bus.busy <= 1'b1;
        rd_q     <= dec_rd;
        base     <= dec_addr[AW-1:0];
        wbuf     <= dec_data;
        cnt      <= 3'd0;
        if (!(dec_wr || dec_rd)) begin
          state          <= DONE;
          bus.done       <= 1'b1;
          bus.dmem_error <= 1'b0;
        end else if (oor) begin
          state          <= DONE;
          bus.done       <= 1'b1;
          bus.dmem_error <= 1'b1;
          if (dec_rd)
            bus.valM <= 64'd0;
        end else begin
          state          <= XFER;
          bus.dmem_error <= 1'b0;
        end
      end
    end
  end

  // Memory is not reset; an aborted write keeps the bytes already stored.
  always_ff @(posedge clk) begin
    if (!reset && state == XFER && !rd_q)
      mem[idx] <= wbuf[7:0];
  end
endmodule
